// File: rtl/game_pkg.sv
// Shared types and constants for the cat/dog game-flow sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AIM,
    THROW,
    SWITCH,
    GAME_OVER
  } state_t;

  localparam logic PLAYER_LEFT  = 1'b1;
  localparam logic PLAYER_RIGHT = 1'b0;

  localparam int HP_W = 4;

  // One hit point lost, never going below zero.
  function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
    return (hp == '0) ? '0 : hp - HP_W'(1);
  endfunction

endpackage

// File: rtl/turn_ctrl_if.sv
// Game-flow bus: player/projectile events in, turn and score status out.
interface turn_ctrl_if;
  import game_pkg::*;

  logic            start;
  logic            throw_req_l;
  logic            throw_req_r;
  logic            proj_landed;
  logic            proj_hit;
  logic            turn;
  logic            throw_flag;
  logic            left;
  logic            throw_launch;
  logic [HP_W-1:0] hp_l;
  logic [HP_W-1:0] hp_r;
  logic            game_over;
  logic            winner_l;

  // Game-board side: drives events, observes the sequencer.
  modport master (
    output start, throw_req_l, throw_req_r, proj_landed, proj_hit,
    input  turn, throw_flag, left, throw_launch, hp_l, hp_r, game_over, winner_l
  );

  // Sequencer side.
  modport slave (
    input  start, throw_req_l, throw_req_r, proj_landed, proj_hit,
    output turn, throw_flag, left, throw_launch, hp_l, hp_r, game_over, winner_l
  );

endinterface

// File: rtl/delay_timer.sv
// Up-counter with synchronous clear, count enable and a terminal-count flag.
// The count holds at the limit so it can never wrap.
module delay_timer #(
  parameter int W = 8
) (
  input  logic         clk60MHz,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_reg;

  assign done = (count_reg == limit);

  // Count towards the limit while enabled; clear restarts from zero.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !done) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/turn_ctrl.sv
// Turn sequencer for the two-player throwing game: grants turns, launches
// throws, resolves hits/misses/timeouts, keeps score and declares the winner.
module turn_ctrl
  import game_pkg::*;
#(
  parameter int MAX_HP        = 3,
  parameter int THROW_TIMEOUT = 300_000_000,
  parameter int SWITCH_DELAY  = 60_000_000
) (
  input logic        clk60MHz,
  input logic        rst_n,
  turn_ctrl_if.slave bus
);

  // One shared timer serves both the flight timeout and the turn pause.
  localparam int LONGEST = (THROW_TIMEOUT > SWITCH_DELAY) ? THROW_TIMEOUT : SWITCH_DELAY;
  localparam int TIMER_W = (LONGEST > 1) ? $clog2(LONGEST) : 1;

  localparam logic [TIMER_W-1:0] THROW_LAST  = TIMER_W'(THROW_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SWITCH_LAST = TIMER_W'(SWITCH_DELAY - 1);
  localparam logic [HP_W-1:0]    HP_INIT     = HP_W'(MAX_HP);

  state_t          state_reg;
  logic            turn_reg;
  logic            throw_flag_reg;
  logic            left_reg;
  logic            launch_reg;
  logic            game_over_reg;
  logic            winner_l_reg;
  logic [HP_W-1:0] hp_l_reg;
  logic [HP_W-1:0] hp_r_reg;

  logic                valid_req;
  logic                hit;
  logic                throw_resolve;
  logic                switch_end;
  logic                timer_run;
  logic                timer_clear;
  logic                timer_done;
  logic                knockout;
  logic [TIMER_W-1:0]  timer_limit;
  logic [HP_W-1:0]     hp_opp;
  logic [HP_W-1:0]     hp_opp_next;

  // Request, resolution and scoring decisions for the current cycle.
  always_comb begin
    valid_req     = (left_reg == PLAYER_LEFT) ? bus.throw_req_l : bus.throw_req_r;
    hit           = bus.proj_landed && bus.proj_hit;
    // A landing and a timeout in the same cycle both resolve here; the hit
    // flag comes from proj_landed, so the landing wins.
    throw_resolve = (state_reg == THROW) && (bus.proj_landed || timer_done);
    switch_end    = (state_reg == SWITCH) && timer_done;
    timer_run     = (state_reg == THROW) || (state_reg == SWITCH);
    // Held at zero outside the timed states and zeroed on every exit, so each
    // timed state starts counting from zero.
    timer_clear   = !timer_run || throw_resolve || switch_end;
    timer_limit   = (state_reg == SWITCH) ? SWITCH_LAST : THROW_LAST;
    hp_opp        = (left_reg == PLAYER_LEFT) ? hp_r_reg : hp_l_reg;
    hp_opp_next   = hit ? hp_dec(hp_opp) : hp_opp;
    knockout      = hit && (hp_opp_next == '0);
  end

  delay_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk60MHz (clk60MHz),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .enable   (timer_run),
    .limit    (timer_limit),
    .done     (timer_done)
  );

  // Game-flow FSM with all outputs registered alongside the state.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      turn_reg       <= 1'b0;
      throw_flag_reg <= 1'b0;
      left_reg       <= PLAYER_LEFT;
      launch_reg     <= 1'b0;
      game_over_reg  <= 1'b0;
      winner_l_reg   <= 1'b0;
      hp_l_reg       <= '0;
      hp_r_reg       <= '0;
    end else begin
      launch_reg <= 1'b0;
      case (state_reg)
        IDLE, GAME_OVER: begin
          if (bus.start) begin
            hp_l_reg      <= HP_INIT;
            hp_r_reg      <= HP_INIT;
            left_reg      <= PLAYER_LEFT;
            turn_reg      <= 1'b1;
            game_over_reg <= 1'b0;
            winner_l_reg  <= 1'b0;
            state_reg     <= AIM;
          end
        end
        AIM: begin
          if (valid_req) begin
            turn_reg       <= 1'b0;
            throw_flag_reg <= 1'b1;
            launch_reg     <= 1'b1;
            state_reg      <= THROW;
          end
        end
        THROW: begin
          if (throw_resolve) begin
            throw_flag_reg <= 1'b0;
            if (left_reg == PLAYER_LEFT) begin
              hp_r_reg <= hp_opp_next;
            end else begin
              hp_l_reg <= hp_opp_next;
            end
            if (knockout) begin
              // The thrower just emptied the opponent, so the thrower wins.
              game_over_reg <= 1'b1;
              winner_l_reg  <= (left_reg == PLAYER_LEFT);
              state_reg     <= GAME_OVER;
            end else begin
              state_reg <= SWITCH;
            end
          end
        end
        SWITCH: begin
          if (switch_end) begin
            left_reg  <= (left_reg == PLAYER_LEFT) ? PLAYER_RIGHT : PLAYER_LEFT;
            turn_reg  <= 1'b1;
            state_reg <= AIM;
          end
        end
        default: begin
          turn_reg       <= 1'b0;
          throw_flag_reg <= 1'b0;
          game_over_reg  <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign bus.turn         = turn_reg;
  assign bus.throw_flag   = throw_flag_reg;
  assign bus.left         = left_reg;
  assign bus.throw_launch = launch_reg;
  assign bus.hp_l         = hp_l_reg;
  assign bus.hp_r         = hp_r_reg;
  assign bus.game_over    = game_over_reg;
  assign bus.winner_l     = winner_l_reg;

endmodule

// File: doc/turn_ctrl.md
Name: turn_ctrl

Overview:
Game-flow sequencer for the two-player cat/dog throwing game. Decides whose turn it is and when a throw is in flight. Tracks hit points and declares the winner. Its turn, throw_flag and left outputs feed the board LED indicator and the projectile/draw logic. All outputs are registered and run in the clk60MHz domain.

Parameters:
MAX_HP, 3, hit points loaded for each player at game start (1..15)
THROW_TIMEOUT, 300_000_000, cycles allowed in flight before the throw is forced to resolve as a miss (5 s)
SWITCH_DELAY, 60_000_000, cycles of pause between landing and the next turn (1 s)

Ports:
clk60MHz  in  1  system clock, 60 MHz
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts or restarts a game (honoured in IDLE and GAME_OVER only)
throw_req_l  in  1  throw request from the left player (one-cycle pulse, synchronous)
throw_req_r  in  1  throw request from the right player
proj_landed  in  1  one-cycle pulse from the projectile block: the projectile has finished
proj_hit  in  1  qualifies proj_landed: the opponent was hit
turn  out  1  1 = the active player may throw (AIM state)
throw_flag  out  1  1 = a projectile is in flight (THROW state)
left  out  1  1 = the left player is active, 0 = the right player is active
throw_launch  out  1  one-cycle pulse starting the projectile
hp_l  out  4  left player hit points
hp_r  out  4  right player hit points
game_over  out  1  1 in GAME_OVER
winner_l  out  1  valid while game_over; 1 = the left player won

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; timer = 0.
  - turn = throw_flag = throw_launch = game_over = winner_l = 0.
  - left = 1; hp_l = hp_r = 0.
- IDLE:
  - All flags are 0.
  - On start: hp_l = hp_r = MAX_HP, left = 1, next state = AIM.
- AIM:
  - turn = 1.
  - Only the active side's request counts: throw_req_l when left = 1, throw_req_r when left = 0. The other request is ignored, including when both arrive in the same cycle.
  - On a valid request, the next cycle has:
    - state = THROW, turn = 0, throw_flag = 1;
    - throw_launch = 1 for exactly that one cycle;
    - timer cleared.
- THROW:
  - The timer increments each cycle.
  - On proj_landed with proj_hit = 1, the opponent's hp decrements, saturating at 0.
  - On proj_landed with proj_hit = 0, hp is unchanged.
  - If timer reaches THROW_TIMEOUT-1 with no proj_landed, the throw resolves as a miss.
  - If proj_landed and the timeout coincide, proj_landed takes priority.
  - Next state: GAME_OVER if the decremented hp = 0; otherwise SWITCH with the timer cleared. throw_flag drops the same cycle.
  - proj_landed outside THROW is ignored.
- SWITCH:
  - turn = 0, throw_flag = 0.
  - After SWITCH_DELAY cycles (timer reaches SWITCH_DELAY-1): left toggles, state = AIM.
  - Throw requests in this state are ignored; they are not queued.
- GAME_OVER:
  - game_over = 1; winner_l = 1 if hp_r = 0, else 0.
  - hp values are held.
  - start re-initialises exactly as in IDLE.
- start in AIM, THROW or SWITCH is ignored.
- Timer: width $clog2(max(THROW_TIMEOUT, SWITCH_DELAY)); it never wraps, because it is always cleared on state entry.
- Reset mid-game: rst_n low immediately forces the reset values above. A throw in flight is abandoned and no throw_launch is emitted.

Decomposition:
- game_pkg:
  - typedef enum logic [2:0] state_t {IDLE, AIM, THROW, SWITCH, GAME_OVER};
  - constants PLAYER_LEFT = 1'b1 and PLAYER_RIGHT = 1'b0;
  - HP_W = 4.
- Sub-module delay_timer: clear/enable/terminal-count compare, parameterised width and limit. turn_ctrl instantiates it once and reloads the limit per state.

Test Plan:
Bench parameters: MAX_HP=2, THROW_TIMEOUT=20, SWITCH_DELAY=5.
1. Reset then start -> hp_l = hp_r = 2, left = 1, turn = 1 one cycle later; throw_req_r in this state -> no change.
2. throw_req_l -> next cycle throw_launch = 1 for exactly one cycle and throw_flag = 1. Then proj_landed with proj_hit = 1 -> hp_r = 1. Exactly 5 cycles later left = 0 and turn = 1.
3. Right player's turn: throw_req_r, then no proj_landed for 20 cycles -> timeout resolves as a miss, hp_l stays 2, and SWITCH follows.
4. Left hits twice in total -> hp_r = 0, state = GAME_OVER, game_over = 1, winner_l = 1. A further proj_landed or throw_req has no effect; start -> hp = 2/2, left = 1.
5. proj_landed and timeout in the same cycle with proj_hit = 1 -> the hit is counted, not a miss. throw_req_l and throw_req_r in the same AIM cycle -> only the active side launches.
6. rst_n asserted in THROW and mid-SWITCH -> all outputs go to reset values asynchronously, without waiting for a clock edge; after release the block stays in IDLE until start.
